// File: rtl/alu_iter_exec.sv
// Multi-cycle ALU execute stage: logic/arith ops in one cycle, shifts iterated one bit per cycle.
// Request accepted on in_valid & in_ready; result held on out_valid until out_ready.
module alu_iter_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [1:0]      dbg_state
);

  // ALUSel encoding: {funct7[5], funct3} of the RV32I R-type ops.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;
  logic [3:0]      sel_q;
  logic [XLEN-1:0] acc_q;
  logic [SHW-1:0]  cnt_q;

  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic [XLEN-1:0] alu_d;
  logic            illegal_d;
  logic [XLEN-1:0] acc_d;

  assign shamt     = op_b[SHW-1:0];
  assign is_shift  = (alu_sel == ALU_SLL) || (alu_sel == ALU_SRL) || (alu_sel == ALU_SRA);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;

  // Single-cycle result; shifts pass op_a through so shamt==0 completes here too.
  always_comb begin
    alu_d     = '0;
    illegal_d = 1'b0;
    case (alu_sel)
      ALU_ADD:  alu_d = op_a + op_b;
      ALU_SUB:  alu_d = op_a - op_b;
      ALU_SLT:  alu_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_d = op_a ^ op_b;
      ALU_OR:   alu_d = op_a | op_b;
      ALU_AND:  alu_d = op_a & op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_d = op_a;
      default:  illegal_d = 1'b1;
    endcase
  end

  // One-bit shift step applied to the accumulator in SHIFT.
  always_comb begin
    acc_d = acc_q;
    case (sel_q)
      ALU_SLL: acc_d = {acc_q[XLEN-2:0], 1'b0};
      ALU_SRL: acc_d = {1'b0, acc_q[XLEN-1:1]};
      default: acc_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      sel_q       <= ALU_ADD;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sel_q      <= alu_sel;
            in_ready_q <= 1'b0;
            if (is_shift && (shamt != '0)) begin
              acc_q   <= op_a;
              cnt_q   <= shamt;
              state_q <= S_SHIFT;
            end else begin
              result_q    <= alu_d;
              zero_q      <= (alu_d == '0);
              illegal_q   <= illegal_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            result_q    <= acc_d;
            zero_q      <= (acc_d == '0);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Retire only; the next request waits for IDLE, giving a 2-cycle issue interval.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Bench for alu_iter_exec: directed corner cases plus random ops against a plain-arithmetic model.
module tb_alu_iter_exec;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_errors;

  logic [31:0] exp_q[$];
  logic [31:0] exp_ill_q[$];
  logic [31:0] exp_lat_q[$];

  alu_iter_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic is_legal(input logic [3:0] sel);
    return sel inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                       ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (sel)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 32'($signed(a) >>> sh);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] sel, input logic [31:0] b);
    if ((sel == ALU_SLL || sel == ALU_SRL || sel == ALU_SRA) && (b % 32) != 0)
      return int'(b % 32) + 1;
    return 1;
  endfunction

  // Driver: present a request and return just after the accepting edge.
  task automatic accept_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    alu_sel  = sel;
    op_a     = a;
    op_b     = b;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g == 100) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_sel  = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] er, ei, el;
    exp_q.push_back(ref_result(sel, a, b));
    exp_ill_q.push_back(is_legal(sel) ? 32'd0 : 32'd1);
    exp_lat_q.push_back(32'(ref_latency(sel, b)));
    accept_op(sel, a, b);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    er = exp_q.pop_front();
    ei = exp_ill_q.pop_front();
    el = exp_lat_q.pop_front();
    check({tag, "_lat"}, 32'(lat), el);
    check({tag, "_res"}, result, er);
    check({tag, "_zero"}, 32'(zero), (er == 32'd0) ? 32'd1 : 32'd0);
    check({tag, "_ill"}, 32'(illegal), ei);
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_res"}, result, er);
      check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ret_vld"}, 32'(out_valid), 32'd0);
    check({tag, "_ret_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_zero"}, 32'(zero), 32'd1);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  logic [3:0] legal_tbl[10];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_sel   = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    out_ready = 1'b0;
    legal_tbl = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                  ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("sub", ALU_SUB, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub_zero", ALU_SUB, 32'd5, 32'd5, 0);
    run_op("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 0);
    run_op("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 0);
    run_op("sll_sh0", ALU_SLL, 32'd1, 32'h20, 0);
    run_op("sll_sh3", ALU_SLL, 32'd1, 32'h23, 0);
    run_op("bp_and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5);
    run_op("bp_shift", ALU_SRA, 32'h8765_4321, 32'd7, 5);
    run_op("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 2);
    run_op("illegal2", 4'b1001, 32'hFFFF_FFFF, 32'd3, 0);
    run_op("sll_to_zero", ALU_SLL, 32'h8000_0000, 32'd1, 0);

    // Reset during the 10th cycle of a 31-bit shift
    accept_op(ALU_SRA, 32'h8000_0000, 32'd31);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("midshift_busy", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", ALU_ADD, 32'd2, 32'd3, 0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] sel;
      logic [31:0] a, b;
      sel = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_tbl[$urandom_range(0, 9)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 32'($urandom_range(0, 40));
        default: b = $urandom;
      endcase
      run_op("rand", sel, a, b, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
